// File: rtl/noc_buf_pkg.sv
// noc_buf_pkg: shared flit type and width helpers for the VC input buffer
package noc_buf_pkg;
    localparam int FLIT_W = 8;
    typedef logic [FLIT_W-1:0] flit_t;

    // VC index needs at least one bit even when there is a single VC
    function automatic int vc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Count must hold the value DEPTH itself, hence one extra bit
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int VC_W  = vc_idx_w(2);
    localparam int CNT_W = cnt_w(4);
endpackage

// File: rtl/vc_fifo_ctrl.sv
// vc_fifo_ctrl: pointer and occupancy bookkeeping for one virtual channel
module vc_fifo_ctrl
    import noc_buf_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          push_ok,
    output logic          pop_ok
);
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers wrap naturally; simultaneous accepted push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/vc_input_buffer.sv
// vc_input_buffer: multi-VC router input buffer over a shared flit array (optional VCBUF_OCCUPANCY_EN exposes vc_count)
module vc_input_buffer
    import noc_buf_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int VC_DEPTH   = 4,
    parameter  int NUM_VC     = 2,
    localparam int VW         = vc_idx_w(NUM_VC),
    localparam int PW         = $clog2(VC_DEPTH),
    localparam int CW         = cnt_w(VC_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [VW-1:0]         wr_vc,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [VW-1:0]         rd_vc,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [NUM_VC-1:0]     vc_empty,
    output logic [NUM_VC-1:0]     vc_full,
    output logic                  err_ovf,
    output logic                  err_udf
`ifdef VCBUF_OCCUPANCY_EN
    ,
    output logic [NUM_VC*CW-1:0]  vc_count
`endif
);
    logic [NUM_VC-1:0]     push, pop, push_ok, pop_ok;
    logic [PW-1:0]         wr_ptr [NUM_VC];
    logic [PW-1:0]         rd_ptr [NUM_VC];
    logic [PW-1:0]         wp_sel, rp_sel;
    logic                  rd_hit;
    logic [DATA_WIDTH-1:0] mem [NUM_VC*VC_DEPTH];

    // VC decode; an out-of-range VC matches nothing, so the op is rejected downstream
    always_comb begin
        push   = '0;
        pop    = '0;
        wp_sel = '0;
        rp_sel = '0;
        rd_hit = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            push[i] = wr_en && (wr_vc == VW'(i));
            pop[i]  = rd_en && (rd_vc == VW'(i));
            if (wr_vc == VW'(i)) wp_sel = wr_ptr[i];
            if (rd_vc == VW'(i)) begin
                rp_sel = rd_ptr[i];
                rd_hit = 1'b1;
            end
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_fifo_ctrl #(.DEPTH(VC_DEPTH)) u_ctrl (
            .clk     (clk),
            .rst_n   (rst_n),
            .push    (push[v]),
            .pop     (pop[v]),
            .wr_ptr  (wr_ptr[v]),
            .rd_ptr  (rd_ptr[v]),
`ifdef VCBUF_OCCUPANCY_EN
            .count   (vc_count[v*CW +: CW]),
`else
            .count   (),
`endif
            .empty   (vc_empty[v]),
            .full    (vc_full[v]),
            .push_ok (push_ok[v]),
            .pop_ok  (pop_ok[v])
        );
    end

    // Shared storage, addressed {vc, slot}; contents intentionally not reset
    always_ff @(posedge clk) begin
        if (|push_ok) mem[{wr_vc, wp_sel}] <= wr_data;
    end

    assign rd_data = rd_hit ? mem[{rd_vc, rp_sel}] : '0;

    // Sticky error flags for any rejected write or pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            err_ovf <= err_ovf | (wr_en & ~|push_ok);
            err_udf <= err_udf | (rd_en & ~|pop_ok);
        end
    end
endmodule
